mux4_serializer: RTL

- Upstream feeder for the 4:1 mux. Accepts one 4-lane parallel word on a valid/ready handshake.
- Drives the mux select through lanes 0..3 and presents one lane per accepted output beat on a downstream valid/ready handshake.
- Converts parallel 4-lane words into a serial lane stream for downstream consumers.

---
 rtl/mux_ser_pkg.sv | 32 +++
 rtl/mux4_serializer_if.sv | 28 ++
 rtl/mux4to1.sv | 9 +
 rtl/mux4_serializer.sv | 93 +++++++++
 4 files changed

// File: rtl/mux_ser_pkg.sv
// mux_ser_pkg: shared constants, state enum and lane-order helper for
// mux4_serializer. Lane order follows MUX4_SERIALIZER_MSB_FIRST_EN.
package mux_ser_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef MUX4_SERIALIZER_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_LANE = 2'd3;
    localparam logic [SEL_W-1:0] LAST_LANE  = 2'd0;
`else
    localparam logic [SEL_W-1:0] FIRST_LANE = 2'd0;
    localparam logic [SEL_W-1:0] LAST_LANE  = 2'd3;
`endif

    // Next lane in serialization order (2-bit wrap either way).
    function automatic logic [SEL_W-1:0] next_sel(
        input logic [SEL_W-1:0] s
    );
`ifdef MUX4_SERIALIZER_MSB_FIRST_EN
        return s - 2'd1;
`else
        return s + 2'd1;
`endif
    endfunction

endpackage

// File: rtl/mux4_serializer_if.sv
// mux4_serializer_if: upstream word handshake plus downstream lane beat.
// slave = serializer side, master = producer/consumer side.
interface mux4_serializer_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [4*WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [CNT_W-1:0]   words_done;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel,
        output out_valid, out_last, words_done
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel,
        input  out_valid, out_last, words_done
    );
endinterface

// File: rtl/mux4to1.sv
// mux4to1: 1-bit 4:1 multiplexer.
// Ports: data[3:0] lanes, sel[1:0] lane index, out selected bit.
module mux4to1 (
    input  logic [3:0] data,
    input  logic [1:0] sel,
    output logic       out
);
    assign out = data[sel];
endmodule

// File: rtl/mux4_serializer.sv
// mux4_serializer: holds a 4-lane word and streams one lane per beat.
// Ports: clk, rst (sync, active-high), bus (slave). Macro: MUX4_SERIALIZER_MSB_FIRST_EN.
module mux4_serializer
    import mux_ser_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    mux4_serializer_if.slave   bus
);

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_LANES*WIDTH-1:0] r_word;
    logic [SEL_W-1:0]           r_sel;
    logic [CNT_W-1:0]           r_cnt;

    logic             w_out_valid;
    logic             w_last;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_out_data;

    assign w_out_valid = (r_state == SHIFT);
    // Gate with valid so out_last is low in reset/idle in both lane orders.
    assign w_last      = w_out_valid && (r_sel == LAST_LANE);
    assign w_beat      = w_out_valid && bus.out_ready;
    assign w_last_beat = w_beat && w_last;
    assign w_in_ready  = (r_state == IDLE) || w_last_beat;
    assign w_accept    = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_last_beat && !bus.in_valid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_sel  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_word <= bus.in_data;
                r_sel  <= FIRST_LANE;
            end else if (w_beat) begin
                r_sel  <= next_sel(r_sel);
            end
            if (w_last_beat) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One 4:1 mux per bit position, spanning the same bit of every lane.
    for (genvar b = 0; b < WIDTH; b++) begin : g_mux
        logic [3:0] w_lanes;
        assign w_lanes = {r_word[3*WIDTH+b], r_word[2*WIDTH+b],
                          r_word[WIDTH+b], r_word[b]};
        mux4to1 u_mux (
            .data (w_lanes),
            .sel  (r_sel),
            .out  (w_out_data[b])
        );
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_data   = w_out_data;
    assign bus.out_sel    = r_sel;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_last   = w_last;
    assign bus.words_done = r_cnt;

endmodule
